// File: rtl/shift_sub_divider_pkg.sv
// Shared types and defaults for the restoring shift-subtract divider.
package shift_sub_divider_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } div_state_t;

   localparam int DVD_W_DEF = 8;
   localparam int DVS_W_DEF = 4;
   localparam int CNT_W_DEF = 4;

   // The divide-by-zero quotient is this bit replicated across the quotient width (all ones).
   localparam logic DBZ_QUO_BIT = 1'b1;

endpackage

// File: rtl/shift_sub_divider_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface shift_sub_divider_if
   import shift_sub_divider_pkg::*;
#(
   parameter int DVD_W = DVD_W_DEF,
   parameter int DVS_W = DVS_W_DEF
);
   logic             start;
   logic [DVD_W-1:0] dividend;
   logic [DVS_W-1:0] divisor;
   logic [DVD_W-1:0] quotient;
   logic [DVS_W-1:0] remainder;
   logic             busy;
   logic             done;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, busy, done, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, busy, done, div_by_zero
   );
endinterface

// File: rtl/shift_sub_divider_div_step.sv
// One restoring iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
   parameter int DVS_W = 4
) (
   input  logic [DVS_W-1:0] rem_i,
   input  logic             bit_i,
   input  logic [DVS_W-1:0] dvs_i,
   output logic [DVS_W-1:0] rem_o,
   output logic             q_o
);
   // The extra MSB only exists so the shifted value can be compared before subtraction.
   logic [DVS_W:0] trial;
   logic [DVS_W:0] dvs_ext;

   assign trial   = {rem_i, bit_i};
   assign dvs_ext = {1'b0, dvs_i};
   assign q_o     = (trial >= dvs_ext);
   assign rem_o   = q_o ? DVS_W'(trial - dvs_ext) : trial[DVS_W-1:0];
endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider: unsigned DVD_W / DVS_W, one quotient bit per clock.
//
// state   | meaning
// IDLE    | waiting for start; results held
// CALC    | one restoring step per cycle, DVD_W cycles
// DONE    | results valid, done pulse; start here is accepted back-to-back
module shift_sub_divider
   import shift_sub_divider_pkg::*;
#(
   parameter int DVD_W = DVD_W_DEF,
   parameter int DVS_W = DVS_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   shift_sub_divider_if.slave   bus
);
   div_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DVD_W-1:0] dvd_q, dvd_d;
   logic [DVS_W-1:0] dvs_q, dvs_d;
   logic [DVS_W-1:0] rem_q, rem_d;
   logic [DVD_W-1:0] quo_q, quo_d;
   logic [DVS_W-1:0] remr_q, remr_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;

   logic [DVS_W-1:0] step_rem;
   logic             step_q;

   div_step #(.DVS_W(DVS_W)) u_step (
      .rem_i (rem_q),
      .bit_i (dvd_q[DVD_W-1]),
      .dvs_i (dvs_q),
      .rem_o (step_rem),
      .q_o   (step_q)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      remr_d  = remr_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dbz_d   = dbz_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
            if (bus.start) begin
               dvd_d = bus.dividend;
               dvs_d = bus.divisor;
               rem_d = '0;
               cnt_d = CNT_W'(DVD_W - 1);
               dbz_d = 1'b0;
               if (bus.divisor == '0) begin
                  state_d = ST_DONE;
                  quo_d   = {DVD_W{DBZ_QUO_BIT}};
                  remr_d  = '0;
                  dbz_d   = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_CALC;
                  busy_d  = 1'b1;
               end
            end
         end
         ST_CALC: begin
            // The dividend register doubles as the quotient accumulator.
            dvd_d = {dvd_q[DVD_W-2:0], step_q};
            rem_d = step_rem;
            if (cnt_q == '0) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               quo_d   = {dvd_q[DVD_W-2:0], step_q};
               remr_d  = step_rem;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         remr_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         remr_q  <= remr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   assign bus.quotient    = quo_q;
   assign bus.remainder   = remr_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed and random checks of shift_sub_divider against a division reference model.
module tb_shift_sub_divider;
   logic clk;
   logic reset;

   shift_sub_divider_if bus ();

   shift_sub_divider dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] quo;
      logic [3:0] rem;
      logic       dbz;
      int         lat;
      logic [7:0] dvd;
      logic [3:0] dvs;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive an accepted start for one cycle and queue the model's answer.
   task automatic launch(input logic [7:0] dvd, input logic [3:0] dvs);
      exp_t e;
      e.dvd = dvd;
      e.dvs = dvs;
      if (dvs == 4'd0) begin
         e.quo = 8'hFF;
         e.rem = 4'd0;
         e.dbz = 1'b1;
         e.lat = 1;
      end else begin
         e.quo = 8'(dvd / dvs);
         e.rem = 4'(dvd % dvs);
         e.dbz = 1'b0;
         e.lat = 9;
      end
      sb_q.push_back(e);
      bus.start    = 1'b1;
      bus.dividend = dvd;
      bus.divisor  = dvs;
      tick();
      bus.start = 1'b0;
   endtask

   // Returns in the DONE cycle, having compared the result against the queued expectation.
   task automatic await_done(input bit chk_busy, input int poke, input bit chk_inv);
      int   cyc;
      bit   got;
      exp_t e;
      cyc = 1;
      got = 0;
      while (!got && cyc <= 20) begin
         if (bus.done === 1'b1) begin
            got = 1;
            if (sb_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = sb_q.pop_front();
               check("quotient", 32'(bus.quotient), 32'(e.quo));
               check("remainder", 32'(bus.remainder), 32'(e.rem));
               check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
               check("latency", cyc, e.lat);
               check("busy_at_done", 32'(bus.busy), 0);
               if (chk_inv && e.dvs != 4'd0) begin
                  check("invariant", 32'(bus.quotient) * 32'(e.dvs) + 32'(bus.remainder), 32'(e.dvd));
                  check("rem_lt_dvs", 32'(bus.remainder < e.dvs), 1);
               end
            end
         end else begin
            if (chk_busy) check("busy_calc", 32'(bus.busy), 1);
            if (poke == cyc) begin
               bus.start    = 1'b1;
               bus.dividend = 8'd13;
               bus.divisor  = 4'd3;
            end
            tick();
            bus.start = 1'b0;
            cyc++;
         end
      end
      if (!got) check("done_timeout", 0, 1);
   endtask

   task automatic idle_after_done();
      tick();
      check("done_one_cycle", 32'(bus.done), 0);
      check("busy_idle", 32'(bus.busy), 0);
   endtask

   initial begin
      logic [7:0] r_dvd;
      logic [3:0] r_dvs;
      exp_t       junk;

      reset        = 1'b0;
      bus.start    = 1'b0;
      bus.dividend = 8'd0;
      bus.divisor  = 4'd0;
      #1;
      check("rst_quotient", 32'(bus.quotient), 0);
      check("rst_remainder", 32'(bus.remainder), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_dbz", 32'(bus.div_by_zero), 0);
      tick();
      tick();
      reset = 1'b1;
      tick();

      // Basic
      launch(8'd200, 4'd7);
      await_done(1, 0, 1);
      idle_after_done();
      check("held_quotient", 32'(bus.quotient), 28);

      // Extremes
      launch(8'd255, 4'd1);
      await_done(1, 0, 1);
      idle_after_done();
      launch(8'd5, 4'd15);
      await_done(1, 0, 1);
      idle_after_done();
      launch(8'd255, 4'd15);
      await_done(1, 0, 1);
      idle_after_done();

      // Divide by zero, sticky until next start
      launch(8'd100, 4'd0);
      await_done(0, 0, 0);
      idle_after_done();
      check("dbz_sticky", 32'(bus.div_by_zero), 1);
      check("dbz_quo_held", 32'(bus.quotient), 255);

      // Start during CALC must be ignored
      launch(8'd200, 4'd7);
      await_done(1, 3, 1);
      idle_after_done();
      tick();
      check("no_poke_done", 32'(bus.done), 0);

      // Back-to-back: start held in the DONE cycle
      launch(8'd200, 4'd7);
      await_done(1, 0, 1);
      launch(8'd9, 4'd2);
      check("b2b_busy", 32'(bus.busy), 1);
      await_done(1, 0, 1);
      idle_after_done();

      // Reset in CALC cycle 4
      launch(8'd200, 4'd7);
      tick();
      tick();
      tick();
      check("pre_rst_busy", 32'(bus.busy), 1);
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_quotient", 32'(bus.quotient), 0);
      check("mid_rst_remainder", 32'(bus.remainder), 0);
      check("mid_rst_busy", 32'(bus.busy), 0);
      check("mid_rst_done", 32'(bus.done), 0);
      check("mid_rst_dbz", 32'(bus.div_by_zero), 0);
      check("mid_rst_state", 32'(dut.state_q), 0);
      while (sb_q.size() > 0) junk = sb_q.pop_front();
      tick();
      check("rst_hold_done", 32'(bus.done), 0);
      reset = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("no_done_after_abort", 32'(bus.done), 0);
      end
      launch(8'd50, 4'd6);
      await_done(1, 0, 1);
      idle_after_done();

      // Random operands, mixing idle gaps and back-to-back starts
      for (int n = 0; n < 1000; n++) begin
         r_dvd = 8'($urandom_range(0, 255));
         r_dvs = ($urandom_range(0, 19) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         launch(r_dvd, r_dvs);
         await_done(r_dvs != 4'd0, 0, 1);
         if ($urandom_range(0, 1) == 1) idle_after_done();
      end
      idle_after_done();
      check("queue_empty", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
